oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Bus-sharing controller between the 6502 core and the system memory bus.
- A CPU write of page value P to the trigger address halts the core via RDY.
- It then copies 256 bytes, from {P,00} to {P,FF}, to a fixed destination port address, and releases the core.
- Sits in top between u_core and memory/peripherals. It is the only master mux on the memory bus.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
- DEST_ADDR, 16'h2004, address every DMA byte is written to.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cpu_addr  in  16  core address
- i_cpu_dout  in  8  core write data
- i_cpu_we  in  1  core write strobe (0 = read cycle)
- o_cpu_rdy  out  1  core ready; 0 stalls the core on its next read cycle
- o_mem_addr  out  16  muxed bus address
- o_mem_dout  out  8  muxed bus write data
- o_mem_we  out  1  muxed bus write strobe
- i_mem_din  in  8  bus read data, valid in the same cycle as the address
- o_busy  out  1  high from trigger until release
- o_done  out  1  one-cycle pulse on the final DMA write cycle

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, cnt=0, page=0, data=0, parity=0. Outputs: o_cpu_rdy=1, o_busy=0, o_done=0, o_mem_we follows CPU.
- Parity: a 1-bit register that toggles every cycle after reset.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE
  - Bus = CPU (addr/dout/we pass through); rdy=1.
  - If i_cpu_we=1 and i_cpu_addr==TRIG_ADDR at a clock edge: page<=i_cpu_dout, cnt<=0, next HALT.
  - The trigger write itself still reaches the bus.
- HALT
  - rdy=0, busy=1, bus still = CPU, because 6502 writes ignore RDY (up to 3 further writes are possible).
  - A first cycle with i_cpu_we=0 means the core is frozen. Next state is ALIGN if (DMA_ALIGN_EN and parity==1), else READ.
  - The frozen read still occurs on the bus and is harmlessly repeated after release.
  - Further trigger writes while in HALT are ignored; page is not re-latched.
- ALIGN
  - One dummy cycle: bus addr = {page,cnt}, we=0. Next READ.
- READ
  - Bus addr={page,cnt}, we=0; data<=i_mem_din at the edge. Next WRITE.
- WRITE
  - Bus addr=DEST_ADDR, dout=data, we=1.
  - If cnt==8'hFF: o_done=1 and next IDLE, so rdy=1 in the following cycle.
  - Else: cnt<=cnt+1, next READ.
- Counter: cnt is 8-bit; the transfer ends at FF, and wrap to 00 never starts a new pass.
- Transfer length: exactly 256 READ/WRITE pairs, i.e. 512 bus cycles, plus 0/1 ALIGN cycle, plus HALT cycles (>=1).
- Reset mid-transfer: immediate return to IDLE with rdy=1 and we=0 (async). The partial copy is not resumed.
- The core is stalled throughout HALT..WRITE, so no CPU access reaches the bus during ALIGN/READ/WRITE.
- rdy, busy and the bus mux are combinational from state. The state and datapath registers are the only sequential elements.

Optional Feature:
DMA_ALIGN_EN
- Defined: ALIGN is inserted when leaving HALT on odd parity, so the first READ always lands on an even cycle (513/514-cycle behaviour).
- Undefined: ALIGN is unreachable and is removed; HALT goes straight to READ.
- Parity is still maintained in both cases, so reset values are unchanged.

Decomposition:
- Package dma_pkg: dma_state_t enum (IDLE, HALT, ALIGN, READ, WRITE); default TRIG_ADDR/DEST_ADDR localparams.
- One natural sub-module: dma_bus_mux, a combinational CPU/DMA select of addr/dout/we keyed on a dma_own signal. The FSM and counter stay in oam_dma_ctrl.

Test Plan:
- Fill page 02 with byte i = i^8'h5A. CPU writes 8'h02 to 4014, then reads. Required: 256 writes to 2004 with data 5A,5B,…,A5 in order; rdy=0 for the whole transfer; single o_done pulse.
- Trigger issued when the next CPU cycle is a write, with 2 writes pending. Required: both writes reach the bus while busy=1; DMA starts only after the first read cycle.
- DMA_ALIGN_EN defined, HALT exit on parity=1. Required: exactly one ALIGN cycle; rdy low for 514 cycles with a 1-cycle halt. On parity=0: 513. Macro undefined: 513 in both cases.
- Assert i_rst_n=0 at cnt=8'h40 during WRITE. Required: same-cycle o_mem_we=0, rdy=1, busy=0; a retrigger afterwards restarts at {page,00}.
- Write 8'h07 to 4014 while in HALT after an 8'h03 trigger. Required: source page stays 03.
- Write to 4015 and read 4014. Required: no transfer, rdy stays 1, bus passes through unchanged.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and default addresses for the OAM DMA controller.
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } dma_state_t;

   // CPU write address that starts a transfer.
   localparam logic [15:0] DEF_TRIG_ADDR = 16'h4014;
   // Address every DMA byte is written to.
   localparam logic [15:0] DEF_DEST_ADDR = 16'h2004;

endpackage

// File: rtl/dma_bus_mux.sv
// Memory bus master select: the CPU owns the bus unless the DMA engine
// is actively reading or writing.
module dma_bus_mux (
   input  logic        dma_own,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_dout,
   input  logic        dma_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   output logic        mem_we
);

   // Pure combinational select of address, data and strobe.
   always_comb begin
      if (dma_own) begin
         mem_addr = dma_addr;
         mem_dout = dma_dout;
         mem_we   = dma_we;
      end else begin
         mem_addr = cpu_addr;
         mem_dout = cpu_dout;
         mem_we   = cpu_we;
      end
   end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write of page P to TRIG_ADDR stalls the core
// and copies {P,00}..{P,FF} to DEST_ADDR, then releases the core.
// Optional build macro DMA_ALIGN_EN inserts one ALIGN cycle when leaving
// HALT on odd parity, so the first READ lands on an even cycle.
module oam_dma_ctrl
   import dma_pkg::*;
#(
   parameter logic [15:0] TRIG_ADDR = DEF_TRIG_ADDR,
   parameter logic [15:0] DEST_ADDR = DEF_DEST_ADDR
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_dout,
   input  logic        i_cpu_we,
   output logic        o_cpu_rdy,
   output logic [15:0] o_mem_addr,
   output logic [7:0]  o_mem_dout,
   output logic        o_mem_we,
   input  logic [7:0]  i_mem_din,
   output logic        o_busy,
   output logic        o_done
);

`ifdef DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   dma_state_t  state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [7:0]  page_reg, page_next;
   logic [7:0]  data_reg, data_next;
   logic        parity_reg;

   logic        dma_own;
   logic [15:0] dma_addr;
   logic        dma_we;
   logic        align_req;

   // Alignment is only ever requested on odd parity and when the feature is built in.
   assign align_req = ALIGN_EN && parity_reg;

   // State, datapath and free-running parity registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 8'h00;
         page_reg   <= 8'h00;
         data_reg   <= 8'h00;
         parity_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         page_reg   <= page_next;
         data_reg   <= data_next;
         parity_reg <= ~parity_reg;
      end
   end

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      page_next  = page_reg;
      data_next  = data_reg;
      o_cpu_rdy  = 1'b1;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      dma_own    = 1'b0;
      dma_addr   = {page_reg, cnt_reg};
      dma_we     = 1'b0;
      case (state_reg)
         IDLE: begin
            // The trigger write itself passes through to the bus.
            if (i_cpu_we && (i_cpu_addr == TRIG_ADDR)) begin
               page_next  = i_cpu_dout;
               cnt_next   = 8'h00;
               state_next = HALT;
            end
         end
         HALT: begin
            // Writes ignore RDY, so wait for the first read cycle: the core is frozen then.
            o_cpu_rdy = 1'b0;
            o_busy    = 1'b1;
            if (!i_cpu_we) begin
               state_next = align_req ? ALIGN : READ;
            end
         end
`ifdef DMA_ALIGN_EN
         ALIGN: begin
            o_cpu_rdy  = 1'b0;
            o_busy     = 1'b1;
            dma_own    = 1'b1;
            state_next = READ;
         end
`endif
         READ: begin
            o_cpu_rdy  = 1'b0;
            o_busy     = 1'b1;
            dma_own    = 1'b1;
            data_next  = i_mem_din;
            state_next = WRITE;
         end
         WRITE: begin
            o_cpu_rdy = 1'b0;
            o_busy    = 1'b1;
            dma_own   = 1'b1;
            dma_addr  = DEST_ADDR;
            dma_we    = 1'b1;
            if (cnt_reg == 8'hFF) begin
               o_done     = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next   = cnt_reg + 8'h01;
               state_next = READ;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   dma_bus_mux u_bus_mux (
      .dma_own  (dma_own),
      .cpu_addr (i_cpu_addr),
      .cpu_dout (i_cpu_dout),
      .cpu_we   (i_cpu_we),
      .dma_addr (dma_addr),
      .dma_dout (data_reg),
      .dma_we   (dma_we),
      .mem_addr (o_mem_addr),
      .mem_dout (o_mem_dout),
      .mem_we   (o_mem_we)
   );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: random source pages and CPU write
// patterns checked against a transfer-level reference model.
module tb_oam_dma_ctrl;

   localparam logic [15:0] TRIG = 16'h4014;
   localparam logic [15:0] DEST = 16'h2004;
   localparam logic [15:0] CPU_RD = 16'h8000;

   logic        i_clk;
   logic        i_rst_n;
   logic [15:0] i_cpu_addr;
   logic [7:0]  i_cpu_dout;
   logic        i_cpu_we;
   logic        o_cpu_rdy;
   logic [15:0] o_mem_addr;
   logic [7:0]  o_mem_dout;
   logic        o_mem_we;
   logic [7:0]  i_mem_din;
   logic        o_busy;
   logic        o_done;

   logic [7:0]  mem [0:65535];

   int n_tests;
   int n_fail;
   int edge_cnt;
   int rdy_low;
   int done_cnt;
   int done_idx;
   logic [7:0] dma_q[$];

   oam_dma_ctrl dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_cpu_addr (i_cpu_addr),
      .i_cpu_dout (i_cpu_dout),
      .i_cpu_we   (i_cpu_we),
      .o_cpu_rdy  (o_cpu_rdy),
      .o_mem_addr (o_mem_addr),
      .o_mem_dout (o_mem_dout),
      .o_mem_we   (o_mem_we),
      .i_mem_din  (i_mem_din),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   // Asynchronous-read memory: data valid in the same cycle as the address.
   assign i_mem_din = mem[o_mem_addr];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Count clock edges since reset release; parity at an edge is the count of prior edges mod 2.
   always @(posedge i_clk) begin
      if (!i_rst_n) edge_cnt = 0;
      else          edge_cnt = edge_cnt + 1;
   end

   // Bus monitor, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (!o_cpu_rdy) rdy_low = rdy_low + 1;
         if (o_mem_we && o_mem_addr == DEST && !o_cpu_rdy) dma_q.push_back(o_mem_dout);
         if (o_done) begin
            done_cnt = done_cnt + 1;
            done_idx = dma_q.size() - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Trigger a transfer from page pg, then issue npend further CPU writes, then freeze on a read.
   task automatic start_xfer(input logic [7:0] pg, input int npend, input bit retrig,
                             output int exit_prior);
      int t;
      @(posedge i_clk); #1;
      dma_q.delete();
      rdy_low  = 0;
      done_cnt = 0;
      done_idx = -1;
      t = edge_cnt;
      i_cpu_addr = TRIG;
      i_cpu_dout = pg;
      i_cpu_we   = 1'b1;
      @(negedge i_clk);
      check("trig_addr", o_mem_addr, TRIG);
      check("trig_we", o_mem_we, 1);
      check("trig_rdy", o_cpu_rdy, 1);
      for (int k = 0; k < npend; k++) begin
         @(posedge i_clk); #1;
         i_cpu_addr = (retrig && k == 0) ? TRIG : (16'h0700 + 16'(k));
         i_cpu_dout = (retrig && k == 0) ? 8'h07 : 8'($urandom);
         i_cpu_we   = 1'b1;
         @(negedge i_clk);
         check("pend_addr", o_mem_addr, i_cpu_addr);
         check("pend_dout", o_mem_dout, i_cpu_dout);
         check("pend_we", o_mem_we, 1);
         check("pend_busy", o_busy, 1);
      end
      @(posedge i_clk); #1;
      i_cpu_addr = CPU_RD;
      i_cpu_dout = 8'h00;
      i_cpu_we   = 1'b0;
      exit_prior = t + 1 + npend;
   endtask

   // Wait for release and compare the whole transfer with the reference model.
   task automatic finish_xfer(input logic [7:0] pg, input int npend, input int exit_prior);
      int cyc;
      int al;
      bit ok;
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 800) begin
         @(negedge i_clk); #1;
         cyc++;
         if (o_cpu_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      check("release_seen", ok, 1);
`ifdef DMA_ALIGN_EN
      al = exit_prior % 2;
`else
      al = 0;
`endif
      check("rel_busy", o_busy, 0);
      check("rdy_low_cycles", rdy_low, npend + 1 + al + 512);
      check("dma_writes", dma_q.size(), 256);
      check("done_pulses", done_cnt, 1);
      check("done_on_last", done_idx, 255);
      for (int i = 0; i < 256 && i < dma_q.size(); i++)
         check("dma_data", dma_q[i], mem[{pg, 8'(i)}]);
      $display("[TB] xfer page=%02h pend=%0d align=%0d rdy_low=%0d writes=%0d",
               pg, npend, al, rdy_low, dma_q.size());
   endtask

   task automatic run_xfer(input logic [7:0] pg, input int npend, input bit retrig);
      int ep;
      start_xfer(pg, npend, retrig, ep);
      finish_xfer(pg, npend, ep);
   endtask

   initial begin
      int ep;
      int cyc;
      logic [7:0] pg;
      n_tests  = 0;
      n_fail   = 0;
      edge_cnt = 0;
      rdy_low  = 0;
      done_cnt = 0;
      done_idx = -1;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'h5A;

      // Reset state and pass-through while held in reset.
      i_rst_n    = 1'b0;
      i_cpu_addr = 16'h1234;
      i_cpu_dout = 8'hAB;
      i_cpu_we   = 1'b0;
      #1;
      check("rst_rdy", o_cpu_rdy, 1);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_we", o_mem_we, 0);
      check("rst_addr", o_mem_addr, 16'h1234);
      i_cpu_we = 1'b1;
      #1;
      check("rst_we_follow", o_mem_we, 1);
      check("rst_dout", o_mem_dout, 8'hAB);
      i_cpu_we = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      $display("[TB] reset released");

      // Near-miss accesses: write 4015, read 4014.
      @(posedge i_clk); #1;
      i_cpu_addr = 16'h4015; i_cpu_dout = 8'h02; i_cpu_we = 1'b1;
      @(negedge i_clk);
      check("w4015_addr", o_mem_addr, 16'h4015);
      check("w4015_dout", o_mem_dout, 8'h02);
      check("w4015_we", o_mem_we, 1);
      @(posedge i_clk); #1;
      i_cpu_addr = TRIG; i_cpu_dout = 8'h02; i_cpu_we = 1'b0;
      @(negedge i_clk);
      check("r4014_addr", o_mem_addr, TRIG);
      check("r4014_we", o_mem_we, 0);
      check("r4014_rdy", o_cpu_rdy, 1);
      @(posedge i_clk); #1;
      i_cpu_addr = CPU_RD;
      @(negedge i_clk);
      check("nomiss_busy", o_busy, 0);
      check("nomiss_rdy", o_cpu_rdy, 1);
      $display("[TB] near-miss accesses, no transfer started");

      // Known pattern on page 02.
      run_xfer(8'h02, 0, 1'b0);
      // Two writes pending after the trigger.
      run_xfer(8'($urandom_range(8, 31)), 2, 1'b0);
      // Retrigger with 07 while halted after an 03 trigger.
      run_xfer(8'h03, 1, 1'b1);
      // Random pages, pending writes and parity phases.
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 3)) @(posedge i_clk);
         run_xfer(8'($urandom_range(8, 255)), $urandom_range(0, 3), 1'b0);
      end

      // Reset in the WRITE cycle with cnt=40, then retrigger.
      pg = 8'h04;
      start_xfer(pg, 0, 1'b0, ep);
      cyc = 0;
      while (dma_q.size() < 8'h41 && cyc < 400) begin
         @(negedge i_clk); #1;
         cyc++;
      end
      check("mid_reached", dma_q.size(), 8'h41);
      check("mid_we_before", o_mem_we, 1);
      i_rst_n = 1'b0;
      #1;
      check("mid_we", o_mem_we, 0);
      check("mid_rdy", o_cpu_rdy, 1);
      check("mid_busy", o_busy, 0);
      check("mid_done", o_done, 0);
      $display("[TB] reset asserted mid-transfer after %0d writes", dma_q.size());
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run_xfer(pg, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
